// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter
//   Shares one Binary_to_BCD conversion engine between two requesters.
//   Round-robin arbitration in IDLE, a one-cycle start pulse to the engine,
//   a bounded wait for the engine's result, and a one-cycle response strobe
//   back to the requester that was granted.
//
// Ports
//   i_Clock, i_Rst_L                 clock, asynchronous active-low reset
//   i_ReqN_Valid / i_ReqN_Binary     requester N operand handshake (N = 0,1)
//   o_ReqN_Ready                     combinational accept for requester N
//   o_RespN_Valid/_BCD/_Err          one-cycle result strobe for requester N
//   o_Conv_Start / o_Conv_Binary     engine start pulse and operand
//   i_Conv_DV / i_Conv_BCD           engine result
//   o_Busy                           high whenever the FSM is not in IDLE

// Per-requester handshake and response gating.
module bcd_conv_arbiter_lane #(
    parameter int RES_W = 8
) (
    input  logic             idle,      // FSM in IDLE and out of reset
    input  logic             gnt_hit,   // this requester holds the grant
    input  logic             resp_hit,  // RESP cycle for this requester
    input  logic [RES_W-1:0] res_bcd,
    input  logic             res_err,
    output logic             ready,
    output logic             resp_valid,
    output logic [RES_W-1:0] resp_bcd,
    output logic             resp_err
);
    assign ready      = idle & gnt_hit;
    assign resp_valid = resp_hit;
    // Result fields are forced to 0 outside the strobe.
    assign resp_bcd   = resp_hit ? res_bcd : '0;
    assign resp_err   = resp_hit & res_err;
endmodule

module bcd_conv_arbiter #(
    parameter int INPUT_WIDTH    = 7,
    parameter int DECIMAL_DIGITS = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst_L,
    input  logic                        i_Req0_Valid,
    input  logic [INPUT_WIDTH-1:0]      i_Req0_Binary,
    output logic                        o_Req0_Ready,
    output logic                        o_Resp0_Valid,
    output logic [4*DECIMAL_DIGITS-1:0] o_Resp0_BCD,
    output logic                        o_Resp0_Err,
    input  logic                        i_Req1_Valid,
    input  logic [INPUT_WIDTH-1:0]      i_Req1_Binary,
    output logic                        o_Req1_Ready,
    output logic                        o_Resp1_Valid,
    output logic [4*DECIMAL_DIGITS-1:0] o_Resp1_BCD,
    output logic                        o_Resp1_Err,
    output logic                        o_Conv_Start,
    output logic [INPUT_WIDTH-1:0]      o_Conv_Binary,
    input  logic                        i_Conv_DV,
    input  logic [4*DECIMAL_DIGITS-1:0] i_Conv_BCD,
    output logic                        o_Busy
);
    localparam int NUM_REQ = 2;
    localparam int RES_W   = 4 * DECIMAL_DIGITS;
    localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    // Smallest operand that cannot be represented in DECIMAL_DIGITS digits.
    localparam logic [63:0]      LIMIT   = pow10(DECIMAL_DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic                   last_q;     // requester served most recently
    logic                   gnt_q;      // requester owning the current job
    logic [INPUT_WIDTH-1:0] op_q;
    logic [RES_W-1:0]       res_bcd;
    logic                   res_err;

    logic [NUM_REQ-1:0]                  req_vld;
    logic [NUM_REQ-1:0][INPUT_WIDTH-1:0] req_bin;
    logic                                gnt_any;
    logic                                gnt_id;
    logic                                idle_act;
    logic                                accept;
    logic [INPUT_WIDTH-1:0]              acc_bin;
    logic                                over;

    logic [NUM_REQ-1:0]            lane_ready;
    logic [NUM_REQ-1:0]            lane_rv;
    logic [NUM_REQ-1:0][RES_W-1:0] lane_rb;
    logic [NUM_REQ-1:0]            lane_re;

    assign req_vld = {i_Req1_Valid, i_Req0_Valid};
    assign req_bin = {i_Req1_Binary, i_Req0_Binary};

    // Round-robin: on a tie the requester not served last wins; otherwise
    // the only valid requester wins (req_vld[1] selects it directly).
    always_comb begin
        gnt_any = |req_vld;
        if (&req_vld) gnt_id = ~last_q;
        else          gnt_id = req_vld[1];
    end

    // Ready is combinational, so it is also gated by reset to keep every
    // output low while i_Rst_L is asserted.
    assign idle_act = (state == S_IDLE) && i_Rst_L;
    assign accept   = idle_act && gnt_any;
    assign acc_bin  = req_bin[gnt_id];
    assign over     = 64'(acc_bin) >= LIMIT;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state   <= S_IDLE;
            cnt     <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            op_q    <= '0;
            res_bcd <= '0;
            res_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= acc_bin;
                        gnt_q <= gnt_id;
                        if (over) begin
                            // Out-of-range operand never reaches the engine.
                            res_bcd <= '0;
                            res_err <= 1'b1;
                            state   <= S_RESP;
                        end else begin
                            state <= S_START;
                        end
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // DV is checked first so it wins over a coincident timeout.
                    if (i_Conv_DV) begin
                        res_bcd <= i_Conv_BCD;
                        res_err <= 1'b0;
                        state   <= S_RESP;
                    end else if (cnt == CNT_MAX) begin
                        res_bcd <= '0;
                        res_err <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    last_q <= gnt_q;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        bcd_conv_arbiter_lane #(.RES_W(RES_W)) u_lane (
            .idle       (idle_act),
            .gnt_hit    (gnt_any && (gnt_id == 1'(g))),
            .resp_hit   ((state == S_RESP) && (gnt_q == 1'(g))),
            .res_bcd    (res_bcd),
            .res_err    (res_err),
            .ready      (lane_ready[g]),
            .resp_valid (lane_rv[g]),
            .resp_bcd   (lane_rb[g]),
            .resp_err   (lane_re[g])
        );
    end

    assign o_Req0_Ready  = lane_ready[0];
    assign o_Req1_Ready  = lane_ready[1];
    assign o_Resp0_Valid = lane_rv[0];
    assign o_Resp1_Valid = lane_rv[1];
    assign o_Resp0_BCD   = lane_rb[0];
    assign o_Resp1_BCD   = lane_rb[1];
    assign o_Resp0_Err   = lane_re[0];
    assign o_Resp1_Err   = lane_re[1];

    assign o_Conv_Start  = (state == S_START);
    assign o_Conv_Binary = (state == S_START || state == S_WAIT) ? op_q : '0;
    assign o_Busy        = (state != S_IDLE);
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
module tb_bcd_conv_arbiter;
    localparam int W   = 7;
    localparam int D   = 2;
    localparam int TO  = 64;
    localparam int NEVER = 1000;

    logic         i_Clock, i_Rst_L;
    logic         i_Req0_Valid, i_Req1_Valid;
    logic [W-1:0] i_Req0_Binary, i_Req1_Binary;
    logic         o_Req0_Ready, o_Req1_Ready;
    logic         o_Resp0_Valid, o_Resp1_Valid;
    logic [4*D-1:0] o_Resp0_BCD, o_Resp1_BCD;
    logic         o_Resp0_Err, o_Resp1_Err;
    logic         o_Conv_Start;
    logic [W-1:0] o_Conv_Binary;
    logic         i_Conv_DV;
    logic [4*D-1:0] i_Conv_BCD;
    logic         o_Busy;

    bcd_conv_arbiter #(.INPUT_WIDTH(W), .DECIMAL_DIGITS(D), .TIMEOUT_CYCLES(TO)) dut (
        .i_Clock(i_Clock), .i_Rst_L(i_Rst_L),
        .i_Req0_Valid(i_Req0_Valid), .i_Req0_Binary(i_Req0_Binary), .o_Req0_Ready(o_Req0_Ready),
        .o_Resp0_Valid(o_Resp0_Valid), .o_Resp0_BCD(o_Resp0_BCD), .o_Resp0_Err(o_Resp0_Err),
        .i_Req1_Valid(i_Req1_Valid), .i_Req1_Binary(i_Req1_Binary), .o_Req1_Ready(o_Req1_Ready),
        .o_Resp1_Valid(o_Resp1_Valid), .o_Resp1_BCD(o_Resp1_BCD), .o_Resp1_Err(o_Resp1_Err),
        .o_Conv_Start(o_Conv_Start), .o_Conv_Binary(o_Conv_Binary),
        .i_Conv_DV(i_Conv_DV), .i_Conv_BCD(i_Conv_BCD), .o_Busy(o_Busy)
    );

    initial begin
        i_Clock = 1'b0;
        forever #5 i_Clock = ~i_Clock;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int c       = 0;
    int n_start = 0;

    // Job-level reference model: one outstanding job, its acceptance cycle,
    // the cycle its response is due and what it must carry.
    bit           m_busy, m_errpath, m_last, m_g, m_err;
    int           m_T, m_k, m_resp;
    logic [W-1:0] m_op;
    logic [4*D-1:0] m_bcd;
    int           m_srv [2];
    int           plan_k = 0;   // engine latency for the next job, 0 = random

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, c);
        end
    endtask

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({o_Req0_Ready, o_Req1_Ready, o_Conv_Start, o_Conv_Binary, o_Busy,
                    o_Resp0_Valid, o_Resp0_BCD, o_Resp0_Err,
                    o_Resp1_Valid, o_Resp1_BCD, o_Resp1_Err});
    endfunction

    task automatic model_reset();
        m_busy = 0; m_last = 1; m_errpath = 0;
    endtask

    // One clock cycle; entered and left just after a rising edge.
    task automatic cyc(input bit v0, input logic [W-1:0] b0,
                       input bit v1, input logic [W-1:0] b1, input bit noise);
        bit in_wait, g, v_ok;
        logic [1:0] e_rdy;
        logic e_start, e_busy;
        logic [W-1:0] e_bin;
        logic [9:0] e_r0, e_r1;
        i_Req0_Valid = v0; i_Req0_Binary = b0;
        i_Req1_Valid = v1; i_Req1_Binary = b1;
        in_wait = m_busy && !m_errpath && c >= m_T + 2 && c < m_resp;
        i_Conv_BCD = 8'($urandom);
        i_Conv_DV  = 1'b0;
        if (m_busy && !m_errpath && c == m_T + 1 + m_k) begin
            i_Conv_DV  = 1'b1;
            i_Conv_BCD = to_bcd(int'(m_op));
        end else if (noise && !in_wait) begin
            i_Conv_DV = 1'b1;
        end
        @(negedge i_Clock);
        e_rdy = '0; e_start = 0; e_busy = 0; e_bin = '0; e_r0 = '0; e_r1 = '0;
        g = 0;
        v_ok = v0 || v1;
        if (!m_busy) begin
            if (v_ok) begin
                g = (v0 && v1) ? !m_last : v1;
                e_rdy[g] = 1'b1;
            end
        end else begin
            e_busy = 1;
            if (c == m_resp) begin
                if (m_g) e_r1 = {1'b1, m_bcd, m_err};
                else     e_r0 = {1'b1, m_bcd, m_err};
            end else begin
                e_bin = m_op;
                e_start = (c == m_T + 1);
            end
        end
        chk("ready", 64'({o_Req1_Ready, o_Req0_Ready}), 64'(e_rdy));
        chk("conv_start", 64'(o_Conv_Start), 64'(e_start));
        chk("conv_bin", 64'(o_Conv_Binary), 64'(e_bin));
        chk("busy", 64'(o_Busy), 64'(e_busy));
        chk("resp0", 64'({o_Resp0_Valid, o_Resp0_BCD, o_Resp0_Err}), 64'(e_r0));
        chk("resp1", 64'({o_Resp1_Valid, o_Resp1_BCD, o_Resp1_Err}), 64'(e_r1));
        if (o_Conv_Start) n_start++;
        if (m_busy && c == m_resp) begin
            m_busy = 0; m_last = m_g; m_srv[m_g]++;
        end else if (!m_busy && v_ok) begin
            m_busy = 1; m_T = c; m_g = g;
            m_op = g ? b1 : b0;
            if (int'(m_op) >= 10 ** D) begin
                m_errpath = 1; m_resp = c + 1; m_err = 1; m_bcd = '0; m_k = NEVER;
            end else begin
                m_errpath = 0;
                if (plan_k != 0) m_k = plan_k;
                else m_k = ($urandom_range(0, 15) == 0) ? NEVER : int'($urandom_range(1, 6));
                if (m_k <= TO) begin
                    m_resp = c + 2 + m_k; m_err = 0; m_bcd = to_bcd(int'(m_op));
                end else begin
                    m_resp = c + 2 + TO; m_err = 1; m_bcd = '0;
                end
            end
        end
        @(posedge i_Clock);
        #1;
        c++;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && m_busy; i++) cyc(0, '0, 0, '0, 0);
        if (m_busy) chk("drain_bound", 64'(0), 64'(1));
    endtask

    // Serve one job from each requester with both raising Valid together.
    task automatic tie(input logic [W-1:0] b0, input logic [W-1:0] b1);
        int s0, s1, i;
        s0 = m_srv[0]; s1 = m_srv[1];
        for (i = 0; i < 300 && !(m_srv[0] != s0 && m_srv[1] != s1); i++)
            cyc(m_srv[0] == s0, b0, m_srv[1] == s1, b1, 0);
        if (i == 300) chk("tie_bound", 64'(0), 64'(1));
    endtask

    initial begin
        int s_start;
        i_Rst_L = 1'b0;
        i_Req0_Valid = 1; i_Req1_Valid = 1;
        i_Req0_Binary = 7'd5; i_Req1_Binary = 7'd6;
        i_Conv_DV = 1; i_Conv_BCD = 8'h55;
        m_srv[0] = 0; m_srv[1] = 0;
        model_reset();
        @(posedge i_Clock); @(posedge i_Clock); #1;
        chk("reset_outs", all_outs(), 64'(0));
        i_Req0_Valid = 0; i_Req1_Valid = 0; i_Conv_DV = 0;
        i_Rst_L = 1'b1;

        // Single requester, engine answers at k=3 -> Resp0 at T+5.
        plan_k = 3;
        cyc(1, 7'd10, 0, '0, 0);
        drain();

        // Fresh reset, then a tie 11/99: requester 0 first.
        #2 i_Rst_L = 0;
        model_reset();
        @(posedge i_Clock); #1 i_Rst_L = 1;
        plan_k = 2;
        tie(7'd11, 7'd99);

        // Both held valid for four jobs: grants alternate, four starts.
        s_start = n_start;
        plan_k = 0;
        for (int j = 0; j < 2; j++) tie(7'($urandom_range(0, 99)), 7'($urandom_range(0, 99)));
        chk("four_starts", 64'(n_start - s_start), 64'(4));

        // Out-of-range operand: error at T+1, engine untouched.
        s_start = n_start;
        cyc(0, '0, 1, 7'd100, 1);
        drain();
        chk("no_start_oor", 64'(n_start - s_start), 64'(0));

        // Engine silent -> timeout; DV in the last WAIT cycle still wins.
        plan_k = NEVER;
        cyc(1, 7'd55, 0, '0, 0);
        drain();
        plan_k = TO;
        cyc(0, '0, 1, 7'd37, 0);
        drain();

        // Reset mid-WAIT: outputs drop at once, late DV is ignored.
        plan_k = NEVER;
        cyc(0, '0, 1, 7'd42, 0);
        for (int j = 0; j < 5; j++) cyc(1, 7'd9, 1, 7'd42, 0);
        i_Req0_Valid = 1; i_Req1_Valid = 1;
        #2 i_Rst_L = 0;
        #1 chk("midwait_rst_outs", all_outs(), 64'(0));
        model_reset();
        @(posedge i_Clock); #1;
        chk("rst_hold_outs", all_outs(), 64'(0));
        i_Rst_L = 1;
        cyc(0, '0, 0, '0, 1);
        cyc(0, '0, 0, '0, 1);
        plan_k = 4;
        tie(7'd7, 7'd42);

        // Randomized traffic with spurious DV outside WAIT.
        plan_k = 0;
        for (int j = 0; j < 600; j++)
            cyc(($urandom & 1) == 1, 7'($urandom_range(0, 127)),
                ($urandom & 1) == 1, 7'($urandom_range(0, 127)),
                $urandom_range(0, 3) == 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 Parameter INPUT_WIDTH, default 7, binary operand width.
REQ-002 Parameter DECIMAL_DIGITS, default 2, BCD result digits; result width is 4*DECIMAL_DIGITS.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, maximum number of WAIT cycles before the converter is declared hung.
REQ-004 i_Clock  input  1  single clock; all state changes on its rising edge.
REQ-005 i_Rst_L  input  1  asynchronous, active-low reset.
REQ-006 i_Req0_Valid  input  1  requester 0 has an operand.
REQ-007 i_Req0_Binary  input  INPUT_WIDTH  requester 0 operand.
REQ-008 o_Req0_Ready  output  1  requester 0 operand accepted this cycle when Valid is also high.
REQ-009 o_Resp0_Valid  output  1  one-cycle result strobe for requester 0.
REQ-010 o_Resp0_BCD  output  4*DECIMAL_DIGITS  result for requester 0.
REQ-011 o_Resp0_Err  output  1  error flag, qualified by o_Resp0_Valid.
REQ-012 Ports i_Req1_Valid, i_Req1_Binary, o_Req1_Ready, o_Resp1_Valid, o_Resp1_BCD and o_Resp1_Err are identical to REQ-006 to REQ-011, for requester 1.
REQ-013 o_Conv_Start  output  1  one-cycle start pulse to the shared Binary_to_BCD engine.
REQ-014 o_Conv_Binary  output  INPUT_WIDTH  operand to the engine.
REQ-015 i_Conv_DV  input  1  engine result valid.
REQ-016 i_Conv_BCD  input  4*DECIMAL_DIGITS  engine result.
REQ-017 o_Busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states are IDLE, START, WAIT and RESP.
REQ-019 Arbitration in IDLE is round-robin. With one requester valid, that requester is granted. With both valid, the requester not served last is granted.
REQ-020 The last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-021 o_ReqN_Ready is combinational. It is high only in IDLE, and only for the granted requester. Acceptance is Valid && Ready in the same cycle (cycle T).
REQ-022 On acceptance, the operand and the grant ID are registered.
REQ-023 An accepted operand at or above 10**DECIMAL_DIGITS goes IDLE->RESP with Err=1 and BCD=0. The engine is not started.
REQ-024 Any other accepted operand goes IDLE->START.
REQ-025 START lasts one cycle (T+1): o_Conv_Start=1, then the FSM goes to WAIT.
REQ-026 o_Conv_Binary holds the registered operand from START through WAIT. It is 0 otherwise.
REQ-027 In WAIT, a cycle counter starts at 0. If i_Conv_DV=1, i_Conv_BCD is captured and the FSM goes to RESP with Err=0.
REQ-028 If the counter equals TIMEOUT_CYCLES-1 and i_Conv_DV=0, the FSM goes to RESP with Err=1 and BCD=0.
REQ-029 If DV and timeout occur in the same cycle, DV wins.
REQ-030 i_Conv_DV is ignored outside WAIT.
REQ-031 If the engine asserts DV in cycle T+1+k (k>=1), o_RespN_Valid pulses in cycle T+2+k.
REQ-032 RESP lasts one cycle. o_RespN_Valid, o_RespN_BCD and o_RespN_Err are driven for the granted ID only. The pointer is updated to the granted ID. The next state is IDLE.
REQ-033 A new request cannot be accepted in the RESP cycle. The earliest next acceptance is the cycle after RESP.
REQ-034 Response BCD/Err outputs are 0 whenever the matching o_RespN_Valid=0.
REQ-035 A requester dropping Valid before acceptance is legal. Nothing is latched for it.

Reset
REQ-036 i_Rst_L=0 immediately forces state to IDLE, counter to 0, pointer to 1, and registered operand/result to 0.
REQ-037 During reset all outputs are 0, including o_Conv_Start, both Ready signals, both Resp signals and o_Busy.
REQ-038 Reset in any state, including mid-WAIT, aborts the job with no response. A late i_Conv_DV after reset release is ignored, because the FSM is in IDLE.
REQ-039 After release, the first rising edge with i_Rst_L=1 evaluates IDLE arbitration normally.

Verification
REQ-040 Req0 Binary=10 and the engine model returns DV with 8'h10 at k=3. Required: o_Resp0_Valid for one cycle at T+5 with BCD=8'h10 and Err=0, and o_Resp1_Valid never asserted.
REQ-041 After reset, Req0=11 and Req1=99 go valid in the same cycle. Required: Req0 is granted first (Resp0 BCD=8'h11), then Req1 is accepted the cycle after RESP (Resp1 BCD=8'h99).
REQ-042 Both requesters are held valid continuously for four jobs. Required: grants alternate 0,1,0,1, and o_Conv_Start pulses exactly four times.
REQ-043 Req1 Binary=100 (7'h64). Required: o_Resp1_Valid at T+1 with Err=1 and BCD=0, and no o_Conv_Start pulse.
REQ-044 The engine model never asserts DV. Required: Err=1 and BCD=0 response at T+2+TIMEOUT_CYCLES (T+66 at default), and a DV injected in the final WAIT cycle instead yields Err=0.
REQ-045 i_Rst_L is pulsed low mid-WAIT. Required: all outputs go to 0 at once with no response pulse, and a later Req1=42 plus Req0=7 tie grants Req0 first.
